sensor_drain_scheduler: RTL and testbench
=========================================

# sensor_drain_scheduler

Drains the per-sensor FIFOs (temperature, humidity, motion) into a single framed packet stream for the transmit path. It picks one non-empty FIFO per packet by fixed priority: motion > temperature > humidity. Optional aging keeps humidity from starving. The packet is a header word followed by a burst of up to MAX_BURST data words. The block sits between the sensor FIFOs and the uplink/packet formatter and is the only agent that pops those FIFOs.

## Interface
- MAX_BURST, 8, maximum data words per packet; legal range 1..15.
- AGE_LIMIT, 4, number of lost arbitrations after which a channel is starved (aging build only); legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sched_en  in  1  allows new packets to start; a packet already in flight always completes.
- temp_empty, hum_empty, motion_empty  in  1 each  FIFO empty flags.
- temp_count, hum_count, motion_count  in  4 each  FIFO occupancy.
- temp_rdata, hum_rdata, motion_rdata  in  16 each  FIFO head word; FIFOs are first-word-fall-through, so the head is valid whenever the FIFO is not empty.
- temp_pop, hum_pop, motion_pop  out  1 each  consumes the head word in the same cycle.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  16  header or data word.
- out_sop, out_eop  out  1 each  first word and last word of a packet.
- busy  out  1  high when state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE -> HEADER when sched_en=1 and any FIFO is non-empty; on that edge the block latches sel and len.
  - HEADER -> DATA on out_valid && out_ready.
  - DATA -> IDLE on the handshake of the last data word.
- len = min(count of the selected FIFO, MAX_BURST), always ≥1. The latched len stays safe because only this block pops, so count can only grow.
- Header word fields:
  - [15:14] sensor id: 01 temp, 10 hum, 11 motion; 00 is reserved.
  - [13:10] len.
  - [9:2] seq.
  - [1:0] 2'b00.
- seq is an 8-bit packet counter. It increments on each header handshake and wraps 255 -> 0.
- HEADER: out_valid=1, out_sop=1, out_data=header.
- DATA: out_valid=1, out_data=head word of the selected FIFO, selected pop = out_ready. out_eop=1 on word number len.
- Exactly one pop, or none, is active in any cycle. No pop occurs outside DATA.
- out_valid, once asserted, holds with stable out_data until the handshake completes. The sender never withdraws a word.
- Deasserting sched_en during HEADER or DATA has no effect until the packet finishes.

## Timing
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_data=0, all pops=0, busy=0, state=IDLE, seq=0, all ages=0.
- Latency: a FIFO that is non-empty while IDLE at edge N produces its header valid in cycle N+1.
- With out_ready held at 1, a packet of len words takes 1+len cycles.
- After the last data handshake there is one mandatory IDLE cycle before the next header.
- FIFO flags are sampled only in IDLE. A FIFO becoming non-empty mid-packet waits for the next IDLE.
- If several requests are present in the same IDLE cycle, the winner follows the priority rules below.
- Reset asserted mid-packet returns the block to IDLE immediately and drops pops and out_valid in the same cycle. The packet is truncated; the FIFOs keep their unpopped words.

## Configuration
- SCHED_AGING_EN defined:
  - Each channel has a 4-bit age counter.
  - On every IDLE->HEADER transition, the selected channel's age clears to 0.
  - Every other non-empty channel increments its age, saturating at AGE_LIMIT.
  - Every empty channel's age clears to 0.
  - A channel with age == AGE_LIMIT is starved. Starved channels beat non-starved ones; ties among starved channels are broken by base priority.
- SCHED_AGING_EN undefined: strict motion > temp > hum priority, and no age registers exist.

## Structure
- iot_sensor_pkg holds:
  - a sensor id enum (SID_TEMP=2'b01, SID_HUM=2'b10, SID_MOTION=2'b11);
  - the scheduler state enum (IDLE, HEADER, DATA);
  - the header field bit-position constants.
- One sub-module, sched_pick: combinational selection from empty flags and ages (aging build), producing a one-hot select plus a valid. It is instantiated once.

## Test plan
- Only temp holds 3 words (A1,A2,A3), out_ready=1 → header 0x4C00 (id 01, len 3, seq 0) with sop, then A1, A2, A3 with eop on A3; temp_pop is high for exactly 3 cycles.
- Motion and temp hold 2 words each, both present in the same IDLE → motion packet first (header id 11, seq 0), one IDLE cycle, then the temp packet with seq 1.
- temp_count=12, MAX_BURST=8 → first packet len 8, second packet len 4; seq is consecutive.
- out_ready toggles 1,0,0,1 during DATA → out_data is held stable while out_ready=0, and no pop occurs in those cycles.
- Aging build, AGE_LIMIT=4, motion and hum continuously refilled → hum is served as the 5th packet. Without SCHED_AGING_EN, hum is never served.
- rst_n pulsed low in the 2nd DATA cycle → out_valid and pop fall immediately and seq returns to 0; after release, a fresh header is issued with seq 0.

Source files
------------

// File: rtl/iot_sensor_pkg.sv
`default_nettype none
// ============================================================================
// iot_sensor_pkg : shared types and header layout for the sensor scheduler
// Rev 1.0
// ============================================================================
package iot_sensor_pkg;

    typedef enum logic [1:0] {
        SID_RSVD   = 2'b00,
        SID_TEMP   = 2'b01,
        SID_HUM    = 2'b10,
        SID_MOTION = 2'b11
    } sensor_id_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } sched_state_e;

    // One-hot channel bit positions
    localparam int CH_TEMP   = 0;
    localparam int CH_HUM    = 1;
    localparam int CH_MOTION = 2;

    localparam int HDR_ID_MSB  = 15;
    localparam int HDR_ID_LSB  = 14;
    localparam int HDR_LEN_MSB = 13;
    localparam int HDR_LEN_LSB = 10;
    localparam int HDR_SEQ_MSB = 9;
    localparam int HDR_SEQ_LSB = 2;

    function automatic sensor_id_e sid_of(input logic [2:0] sel_oh);
        case (sel_oh)
            3'b001:  sid_of = SID_TEMP;
            3'b010:  sid_of = SID_HUM;
            3'b100:  sid_of = SID_MOTION;
            default: sid_of = SID_RSVD;
        endcase
    endfunction

    function automatic logic [15:0] make_header(input sensor_id_e sid,
                                                input logic [3:0] len,
                                                input logic [7:0] seq);
        logic [15:0] h;
        h = '0;
        h[HDR_ID_MSB:HDR_ID_LSB]   = sid;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        h[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_pick.sv
`default_nettype none
// ============================================================================
// sched_pick : one-hot channel selection, motion > temp > hum, with optional
//              starvation override when SCHED_AGING_EN is defined.
// Rev 1.0
// ============================================================================
module sched_pick
    import iot_sensor_pkg::*;
`ifdef SCHED_AGING_EN
#(
    parameter int AGE_LIMIT = 4
)
`endif
(
    input  logic [2:0]      i_req,
`ifdef SCHED_AGING_EN
    input  logic [2:0][3:0] i_age,
`endif
    output logic [2:0]      o_sel,
    output logic            o_valid
);

    logic [2:0] w_cand;

`ifdef SCHED_AGING_EN
    logic [2:0] w_starved;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_starved[i] = i_req[i] && (i_age[i] >= 4'(AGE_LIMIT));
        end
        // Starved requesters shadow everyone else; base priority breaks ties
        w_cand = (|w_starved) ? w_starved : i_req;
    end
`else
    assign w_cand = i_req;
`endif

    always_comb begin
        o_sel = '0;
        if (w_cand[CH_MOTION])    o_sel[CH_MOTION] = 1'b1;
        else if (w_cand[CH_TEMP]) o_sel[CH_TEMP]   = 1'b1;
        else if (w_cand[CH_HUM])  o_sel[CH_HUM]    = 1'b1;
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/sensor_drain_scheduler.sv
`default_nettype none
// ============================================================================
// sensor_drain_scheduler : drains temp/hum/motion FIFOs into framed packets.
// Optional humidity anti-starvation aging: define SCHED_AGING_EN.  Rev 1.0
// ============================================================================
module sensor_drain_scheduler
    import iot_sensor_pkg::*;
#(
    parameter int MAX_BURST = 8
`ifdef SCHED_AGING_EN
    ,
    parameter int AGE_LIMIT = 4
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sched_en,
    input  logic        temp_empty,
    input  logic        hum_empty,
    input  logic        motion_empty,
    input  logic [3:0]  temp_count,
    input  logic [3:0]  hum_count,
    input  logic [3:0]  motion_count,
    input  logic [15:0] temp_rdata,
    input  logic [15:0] hum_rdata,
    input  logic [15:0] motion_rdata,
    output logic        temp_pop,
    output logic        hum_pop,
    output logic        motion_pop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        busy
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_BURST);

    sched_state_e state_q, state_d;
    logic [2:0]   sel_q, sel_d;
    logic [3:0]   len_q, len_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   seq_q, seq_d;

    logic [2:0]   w_req;
    logic [2:0]   w_pick_sel;
    logic         w_pick_valid;
    logic [3:0]   w_pick_count;
    logic [3:0]   w_pick_len;
    logic         w_start;
    logic         w_last;
    logic [15:0]  w_head;

    assign w_req   = ~{motion_empty, hum_empty, temp_empty};
    assign w_start = sched_en && w_pick_valid;
    assign w_last  = (cnt_q == len_q - 4'd1);

`ifdef SCHED_AGING_EN
    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);
    logic [2:0][3:0] age_q, age_d;
`endif

    sched_pick
`ifdef SCHED_AGING_EN
    #(.AGE_LIMIT(AGE_LIMIT))
`endif
    u_pick (
        .i_req   (w_req),
`ifdef SCHED_AGING_EN
        .i_age   (age_q),
`endif
        .o_sel   (w_pick_sel),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_count = temp_count;
        if (w_pick_sel[CH_MOTION])   w_pick_count = motion_count;
        else if (w_pick_sel[CH_HUM]) w_pick_count = hum_count;
        // A non-empty FIFO reporting 0 has wrapped its 4-bit count (16 words)
        if (w_pick_count == 4'd0 || w_pick_count > MAX_LEN) w_pick_len = MAX_LEN;
        else                                                w_pick_len = w_pick_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
`ifdef SCHED_AGING_EN
            age_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
`ifdef SCHED_AGING_EN
            age_q   <= age_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d = HEADER;
                    sel_d   = w_pick_sel;
                    len_d   = w_pick_len;
                    cnt_d   = '0;
                end
            end
            HEADER: begin
                if (out_ready) begin
                    state_d = DATA;
                    seq_d   = seq_q + 8'd1;
                end
            end
            DATA: begin
                if (out_ready) begin
                    if (w_last) state_d = IDLE;
                    else        cnt_d   = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SCHED_AGING_EN
    always_comb begin
        age_d = age_q;
        if (state_q == IDLE && w_start) begin
            for (int i = 0; i < 3; i++) begin
                if (w_pick_sel[i])                 age_d[i] = '0;
                else if (!w_req[i])                age_d[i] = '0;
                else if (age_q[i] < AGE_MAX)       age_d[i] = age_q[i] + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        w_head = temp_rdata;
        if (sel_q[CH_MOTION])   w_head = motion_rdata;
        else if (sel_q[CH_HUM]) w_head = hum_rdata;
    end

    always_comb begin
        out_valid  = (state_q != IDLE);
        out_sop    = (state_q == HEADER);
        out_eop    = (state_q == DATA) && w_last;
        busy       = (state_q != IDLE);
        temp_pop   = (state_q == DATA) && sel_q[CH_TEMP]   && out_ready;
        hum_pop    = (state_q == DATA) && sel_q[CH_HUM]    && out_ready;
        motion_pop = (state_q == DATA) && sel_q[CH_MOTION] && out_ready;
        out_data   = '0;
        if (state_q == HEADER)    out_data = make_header(sid_of(sel_q), len_q, seq_q);
        else if (state_q == DATA) out_data = w_head;
    end

endmodule
`default_nettype wire

// File: tb/tb_sensor_drain_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sensor_drain_scheduler : directed bench with FWFT FIFO models.
// Rev 1.0
// ============================================================================
module tb_sensor_drain_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sched_en;
    logic        temp_empty, hum_empty, motion_empty;
    logic [3:0]  temp_count, hum_count, motion_count;
    logic [15:0] temp_rdata, hum_rdata, motion_rdata;
    logic        temp_pop, hum_pop, motion_pop;
    logic        out_valid, out_ready, out_sop, out_eop, busy;
    logic [15:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO models: index 0 temp, 1 hum, 2 motion
    logic [15:0] fmem [3][64];
    int          rd [3];
    int          wr [3];

    always #5 clk = ~clk;

    function automatic logic [3:0] cnt4(input int c);
        return (c > 15) ? 4'd15 : 4'(c);
    endfunction

    assign temp_empty   = (wr[0] == rd[0]);
    assign hum_empty    = (wr[1] == rd[1]);
    assign motion_empty = (wr[2] == rd[2]);
    assign temp_count   = cnt4(wr[0] - rd[0]);
    assign hum_count    = cnt4(wr[1] - rd[1]);
    assign motion_count = cnt4(wr[2] - rd[2]);
    assign temp_rdata   = fmem[0][rd[0] % 64];
    assign hum_rdata    = fmem[1][rd[1] % 64];
    assign motion_rdata = fmem[2][rd[2] % 64];

    always @(posedge clk) begin
        if (temp_pop)   rd[0] <= rd[0] + 1;
        if (hum_pop)    rd[1] <= rd[1] + 1;
        if (motion_pop) rd[2] <= rd[2] + 1;
    end

    sensor_drain_scheduler #(
        .MAX_BURST (8)
`ifdef SCHED_AGING_EN
        ,
        .AGE_LIMIT (4)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sched_en     (sched_en),
        .temp_empty   (temp_empty),
        .hum_empty    (hum_empty),
        .motion_empty (motion_empty),
        .temp_count   (temp_count),
        .hum_count    (hum_count),
        .motion_count (motion_count),
        .temp_rdata   (temp_rdata),
        .hum_rdata    (hum_rdata),
        .motion_rdata (motion_rdata),
        .temp_pop     (temp_pop),
        .hum_pop      (hum_pop),
        .motion_pop   (motion_pop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [15:0] v);
        fmem[ch][wr[ch] % 64] = v;
        wr[ch] = wr[ch] + 1;
    endtask

    task automatic wait_hdr(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 20);
        if (!out_valid) check("hdr_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_packet(input string tag, input logic [15:0] exp_hdr, input int ch,
                              input logic [15:0] first, input int len, input int exp_wait);
        int w;
        wait_hdr(w);
        check({tag, "_lat"}, w, exp_wait);
        check({tag, "_hdr"}, out_data, exp_hdr);
        check({tag, "_sop"}, out_sop, 1);
        check({tag, "_hpop"}, {motion_pop, hum_pop, temp_pop}, 0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check({tag, "_dat"}, out_data, first + 16'(i));
            check({tag, "_eop"}, out_eop, (i == len - 1));
            check({tag, "_pop"}, {motion_pop, hum_pop, temp_pop}, 3'b001 << ch);
        end
        @(negedge clk);
        check({tag, "_gap"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        logic [15:0] hdr [5];

        rst_n = 1'b0; sched_en = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) wr[c] = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sopeop", {out_sop, out_eop}, 0);
        check("rst_busy", busy, 0);
        check("rst_pops", {motion_pop, hum_pop, temp_pop}, 0);
        rst_n = 1'b1; sched_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);

        // Single temp packet of 3
        for (int i = 0; i < 3; i++) push(0, 16'hA001 + 16'(i));
        chk_packet("t1", 16'h4C00, 0, 16'hA001, 3, 1);

        // Motion wins over temp, temp follows after one IDLE cycle
        for (int i = 0; i < 2; i++) begin
            push(2, 16'hC001 + 16'(i));
            push(0, 16'hB001 + 16'(i));
        end
        chk_packet("t2m", 16'hC804, 2, 16'hC001, 2, 1);
        chk_packet("t2t", 16'h4808, 0, 16'hB001, 2, 1);

        // 12 words split into 8 + 4
        for (int i = 0; i < 12; i++) push(0, 16'hD000 + 16'(i));
        chk_packet("t3a", 16'h600C, 0, 16'hD000, 8, 1);
        chk_packet("t3b", 16'h5010, 0, 16'hD008, 4, 1);

        // Backpressure during DATA
        for (int i = 0; i < 3; i++) push(0, 16'hE000 + 16'(i));
        wait_hdr(w);
        check("t4_hdr", out_data, 16'h4C14);
        @(negedge clk);
        check("t4_d0", out_data, 16'hE000);
        check("t4_p0", {motion_pop, hum_pop, temp_pop}, 3'b001);
        @(negedge clk);
        out_ready = 1'b0; #1;
        check("t4_d1", out_data, 16'hE001);
        check("t4_hold_pop", {motion_pop, hum_pop, temp_pop}, 0);
        check("t4_hold_vld", out_valid, 1);
        @(negedge clk);
        check("t4_d1b", out_data, 16'hE001);
        check("t4_hold_pop2", {motion_pop, hum_pop, temp_pop}, 0);
        out_ready = 1'b1; #1;
        check("t4_p1", {motion_pop, hum_pop, temp_pop}, 3'b001);
        @(negedge clk);
        check("t4_d2", out_data, 16'hE002);
        check("t4_eop", out_eop, 1);
        @(negedge clk);
        check("t4_gap", out_valid, 0);

        // sched_en gates new packets
        sched_en = 1'b0;
        push(0, 16'h7000);
        repeat (3) @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_valid", out_valid, 0);
        sched_en = 1'b1;
        chk_packet("t5", 16'h4418, 0, 16'h7000, 1, 1);

        // Reset in the 2nd DATA cycle truncates, FIFO keeps the rest
        for (int i = 0; i < 4; i++) push(0, 16'hF000 + 16'(i));
        wait_hdr(w);
        check("t6_hdr", out_data, 16'h501C);
        @(negedge clk);
        @(negedge clk);
        check("t6_d1", out_data, 16'hF001);
        rst_n = 1'b0; #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_pop", {motion_pop, hum_pop, temp_pop}, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_packet("t6r", 16'h4C00, 0, 16'hF001, 3, 1);

        // Motion and hum both loaded; aging decides the 5th packet
        for (int i = 0; i < 40; i++) push(2, 16'h3000 + 16'(i));
        for (int i = 0; i < 10; i++) push(1, 16'h2000 + 16'(i));
        for (int p = 0; p < 5; p++) begin
            wait_hdr(w);
            hdr[p] = out_data;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(out_valid && out_eop) && n < 20);
            check("t7_eop_timeout", {31'd0, out_eop}, 1);
        end
        check("t7_p1", hdr[0], 16'hE004);
        check("t7_p4", hdr[3], 16'hE010);
`ifdef SCHED_AGING_EN
        check("t7_p5", hdr[4], 16'hA014);
`else
        check("t7_p5", hdr[4], 16'hE014);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
